// File: rtl/mp_add_sequencer.sv
// Multi-precision add/subtract sequencer: one 32-bit Brent-Kung adder is reused
// over WORDS cycles, with the inter-slice carry chained through a register.

module bkadder (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);
    logic [31:0] p;
    logic [31:0] gg;
    logic [31:0] pp;
    logic [32:0] c;

    always_comb begin
        p  = a ^ b;
        gg = a & b;
        pp = p;
        // Fold the carry-in into bit 0 so every prefix group already includes it.
        gg[0] = gg[0] | (p[0] & cin);
        for (int d = 1; d < 32; d = d * 2) begin
            for (int i = 2 * d - 1; i < 32; i = i + 2 * d) begin
                gg[i] = gg[i] | (pp[i] & gg[i-d]);
                pp[i] = pp[i] & pp[i-d];
            end
        end
        for (int d = 8; d >= 1; d = d / 2) begin
            for (int i = 3 * d - 1; i < 32; i = i + 2 * d) begin
                gg[i] = gg[i] | (pp[i] & gg[i-d]);
            end
        end
        c    = {gg, cin};
        sum  = p ^ c[31:0];
        cout = c[32];
    end
endmodule

module mp_add_sequencer #(
    parameter int WORDS = 4
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  IN_VALID,
    output logic                  IN_READY,
    input  logic                  SUB,
    input  logic [32*WORDS-1:0]   A,
    input  logic [32*WORDS-1:0]   B,
    output logic                  OUT_VALID,
    input  logic                  OUT_READY,
    output logic [32*WORDS-1:0]   SUM,
    output logic                  COUT,
    output logic                  OVF
);
    localparam int W     = 32 * WORDS;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] idx;
    logic [W-1:0]     opa_reg;
    logic [W-1:0]     opb_reg;
    logic             carry_reg;
    logic [31:0]      slice_a;
    logic [31:0]      slice_b;
    logic [31:0]      slice_sum;
    logic             slice_cout;
    logic             last_slice;
    logic             accept;

    function automatic logic ovf_calc(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb ~^ b_msb) & (s_msb ^ a_msb);
    endfunction

    assign accept     = IN_VALID & IN_READY;
    assign last_slice = (idx == IDX_W'(WORDS - 1));
    assign slice_a    = opa_reg[32*idx +: 32];
    assign slice_b    = opb_reg[32*idx +: 32];

    bkadder u_bkadder (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_reg),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = RUN;
            RUN:     if (last_slice) state_nxt = DONE;
            DONE:    if (OUT_READY) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        IN_READY  = (state == IDLE) & RST_N;
        OUT_VALID = (state == DONE);
    end

    // Operands are only ever consumed after an accept, so they need no reset.
    always_ff @(posedge CLK) begin
        if (accept) begin
            opa_reg <= A;
            opb_reg <= SUB ? ~B : B;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            SUM       <= '0;
            COUT      <= 1'b0;
            OVF       <= 1'b0;
            carry_reg <= 1'b0;
            idx       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        carry_reg <= SUB;
                        idx       <= '0;
                    end
                end
                RUN: begin
                    SUM[32*idx +: 32] <= slice_sum;
                    if (last_slice) begin
                        COUT <= slice_cout;
                        OVF  <= ovf_calc(opa_reg[W-1], opb_reg[W-1], slice_sum[31]);
                    end else begin
                        carry_reg <= slice_cout;
                        idx       <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mp_add_sequencer.sv
// Directed scoreboard bench for mp_add_sequencer (WORDS=4 and WORDS=1 instances).

module tb_mp_add_sequencer;
    localparam int WORDS = 4;
    localparam int W     = 32 * WORDS;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         in_valid, in_ready, sub, out_valid, out_ready, cout, ovf;
    logic [W-1:0] a, b, sum;
    logic         in_valid1, in_ready1, sub1, out_valid1, out_ready1, cout1, ovf1;
    logic [31:0]  a1, b1, sum1;

    mp_add_sequencer #(.WORDS(WORDS)) u_dut4 (
        .CLK(clk), .RST_N(rst_n), .IN_VALID(in_valid), .IN_READY(in_ready), .SUB(sub),
        .A(a), .B(b), .OUT_VALID(out_valid), .OUT_READY(out_ready), .SUM(sum),
        .COUT(cout), .OVF(ovf)
    );

    mp_add_sequencer #(.WORDS(1)) u_dut1 (
        .CLK(clk), .RST_N(rst_n), .IN_VALID(in_valid1), .IN_READY(in_ready1), .SUB(sub1),
        .A(a1), .B(b1), .OUT_VALID(out_valid1), .OUT_READY(out_ready1), .SUM(sum1),
        .COUT(cout1), .OVF(ovf1)
    );

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sbq[$];

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        exp_t       e;
        logic [W:0] t;
        if (s) begin
            e.sum  = x - y;
            e.cout = (x >= y);
            e.ovf  = (x[W-1] != y[W-1]) && (e.sum[W-1] != x[W-1]);
        end else begin
            t      = {1'b0, x} + {1'b0, y};
            e.sum  = t[W-1:0];
            e.cout = t[W];
            e.ovf  = (x[W-1] == y[W-1]) && (e.sum[W-1] != x[W-1]);
        end
        return e;
    endfunction

    task automatic push_exp(input logic [W-1:0] s, input logic c, input logic o);
        exp_t e;
        e.sum  = s;
        e.cout = c;
        e.ovf  = o;
        sbq.push_back(e);
    endtask

    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic s, output int waited);
        int lat;
        @(negedge clk);
        a = x; b = y; sub = s; in_valid = 1'b1;
        waited = 0;
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            check("accept_ready", 128'(in_ready), 128'(1));
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            check("in_ready_run", 128'(in_ready), 128'(0));
            @(posedge clk);
            #1 lat++;
        end
        check("latency", 128'(lat), 128'(WORDS));
        check("in_ready_done", 128'(in_ready), 128'(0));
    endtask

    task automatic recv(input string tag);
        exp_t e;
        int   w;
        w = 0;
        out_ready = 1'b1;
        while (!out_valid && w < 40) begin
            @(posedge clk);
            #1 w++;
        end
        check({tag, "_valid"}, 128'(out_valid), 128'(1));
        if (sbq.size() == 0) begin
            n_cmp++;
            n_bad++;
            $error("FAIL %s_scoreboard: observed result with empty queue", tag);
        end else begin
            e = sbq.pop_front();
            check({tag, "_sum"}, sum, e.sum);
            check({tag, "_cout"}, 128'(cout), 128'(e.cout));
            check({tag, "_ovf"}, 128'(ovf), 128'(e.ovf));
        end
        @(posedge clk);
        #1 out_ready = 1'b0;
        check({tag, "_valid_drop"}, 128'(out_valid), 128'(0));
        check({tag, "_ready_back"}, 128'(in_ready), 128'(1));
    endtask

    initial begin
        #100000;
        $fatal(1, "FAIL watchdog: simulation did not finish in time");
    end

    int           w;
    logic [W-1:0] x, y;
    logic [W-1:0] held_sum;
    logic         held_cout, held_ovf;
    exp_t         e;

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; sub = 1'b0; a = '0; b = '0;
        in_valid1 = 1'b0; out_ready1 = 1'b0; sub1 = 1'b0; a1 = '0; b1 = '0;

        // Reset state while reset is held
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 128'(in_ready), 128'(0));
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_sum", sum, '0);
        check("rst_cout", 128'(cout), 128'(0));
        check("rst_ovf", 128'(ovf), 128'(0));
        check("rst_in_ready1", 128'(in_ready1), 128'(0));
        rst_n = 1'b1;
        #1;
        check("rel_in_ready", 128'(in_ready), 128'(1));

        // Carry ripple across all slices
        push_exp('0, 1'b1, 1'b0);
        send({W{1'b1}}, 128'd1, 1'b0, w);
        recv("ripple");

        // Subtract with and without borrow
        push_exp({{(W-1){1'b1}}, 1'b0}, 1'b0, 1'b0);
        send(128'd5, 128'd7, 1'b1, w);
        recv("sub_borrow");
        push_exp(128'd2, 1'b1, 1'b0);
        send(128'd7, 128'd5, 1'b1, w);
        recv("sub_noborrow");

        // Signed overflow on add and subtract
        push_exp({1'b1, {(W-1){1'b0}}}, 1'b0, 1'b1);
        send({1'b0, {(W-1){1'b1}}}, 128'd1, 1'b0, w);
        recv("ovf_add");
        push_exp({1'b0, {(W-1){1'b1}}}, 1'b1, 1'b1);
        send({1'b1, {(W-1){1'b0}}}, 128'd1, 1'b1, w);
        recv("ovf_sub");

        // Backpressure in DONE with noisy producer
        x = {$urandom, $urandom, $urandom, $urandom};
        y = {$urandom, $urandom, $urandom, $urandom};
        e = model(x, y, 1'b0);
        push_exp(e.sum, e.cout, e.ovf);
        send(x, y, 1'b0, w);
        held_sum = sum; held_cout = cout; held_ovf = ovf;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = ~in_valid;
            a = {$urandom, $urandom, $urandom, $urandom};
            b = {$urandom, $urandom, $urandom, $urandom};
            sub = ~sub;
            @(posedge clk);
            #1;
            check("bp_valid", 128'(out_valid), 128'(1));
            check("bp_ready", 128'(in_ready), 128'(0));
            check("bp_sum", sum, held_sum);
            check("bp_cout", 128'(cout), 128'(held_cout));
            check("bp_ovf", 128'(ovf), 128'(held_ovf));
        end
        in_valid = 1'b0;
        recv("bp");
        x = {$urandom, $urandom, $urandom, $urandom};
        y = {$urandom, $urandom, $urandom, $urandom};
        e = model(x, y, 1'b1);
        push_exp(e.sum, e.cout, e.ovf);
        send(x, y, 1'b1, w);
        check("bp_next_accept_wait", 128'(w), 128'(0));
        recv("bp_next");

        // Reset while the third slice is being computed
        @(negedge clk);
        a = {$urandom, $urandom, $urandom, $urandom};
        b = {$urandom, $urandom, $urandom, $urandom};
        sub = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        check("mid_accepted", 128'(in_ready), 128'(0));
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check("mid_rst_valid", 128'(out_valid), 128'(0));
        check("mid_rst_sum", sum, '0);
        check("mid_rst_cout", 128'(cout), 128'(0));
        check("mid_rst_ready", 128'(in_ready), 128'(1));
        push_exp(128'd7, 1'b0, 1'b0);
        send(128'd3, 128'd4, 1'b0, w);
        recv("post_rst");

        // Mixed random operations
        for (int i = 0; i < 6; i++) begin
            x = {$urandom, $urandom, $urandom, $urandom};
            y = (i == 4) ? x : {$urandom, $urandom, $urandom, $urandom};
            e = model(x, y, i[0]);
            push_exp(e.sum, e.cout, e.ovf);
            send(x, y, i[0], w);
            recv("rand");
        end

        // Single-slice build
        @(negedge clk);
        a1 = 32'hFFFF_FFFF; b1 = 32'hFFFF_FFFF; sub1 = 1'b0; in_valid1 = 1'b1;
        check("w1_ready", 128'(in_ready1), 128'(1));
        @(posedge clk);
        #1 in_valid1 = 1'b0;
        check("w1_run_valid", 128'(out_valid1), 128'(0));
        @(posedge clk);
        #1;
        check("w1_valid", 128'(out_valid1), 128'(1));
        check("w1_sum", 128'(sum1), 128'(32'hFFFF_FFFE));
        check("w1_cout", 128'(cout1), 128'(1));
        check("w1_ovf", 128'(ovf1), 128'(0));
        out_ready1 = 1'b1;
        @(posedge clk);
        #1 out_ready1 = 1'b0;
        check("w1_valid_drop", 128'(out_valid1), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mp_add_sequencer.md
Name: mp_add_sequencer

Overview:
Multi-precision add/subtract sequencer. It reuses one 32-bit Brent-Kung adder instance (`bkadder`) over WORDS cycles to add or subtract WORDS×32-bit operands. The carry is chained between slices in a register. It sits between an operand producer and a result consumer, with valid/ready handshakes on both sides. Throughput is one operation per WORDS+2 cycles or more (no overlap).

Parameters:
WORDS, 4, number of 32-bit slices per operand (legal range ≥1); total width W = 32*WORDS.

Ports:
CLK  input  1  rising-edge clock.
RST_N  input  1  synchronous active-low reset.
IN_VALID  input  1  operand request valid.
IN_READY  output  1  block can accept a request.
SUB  input  1  0 = A+B, 1 = A−B; sampled with operands.
A  input  W  operand A, unsigned/two's complement.
B  input  W  operand B.
OUT_VALID  output  1  result valid.
OUT_READY  input  1  consumer accepts result.
SUM  output  W  result (mod 2^W).
COUT  output  1  carry out of bit W−1. For SUB: 1 = no borrow (A ≥ B unsigned).
OVF  output  1  signed two's-complement overflow of the W-bit result.

Behaviour:
- One clock (CLK), synchronous active-low reset RST_N.
- All state, including outputs, changes only on the rising edge of CLK.
- Reset (RST_N=0 sampled at an edge):
  - state → IDLE, slice index → 0, carry reg → 0.
  - SUM → 0, COUT → 0, OVF → 0, OUT_VALID → 0.
  - Any in-flight operation is aborted, with no partial result emitted.
  - IN_READY = (state==IDLE) & RST_N, so it reads 0 while reset is held.
- FSM states IDLE, RUN, DONE:
  - IDLE:
    - IN_READY=1, OUT_VALID=0.
    - On IN_VALID&IN_READY at an edge: latch A into opA_reg, latch (SUB ? ~B : B) into opB_reg, carry reg ← SUB, idx ← 0, sub_reg ← SUB; go to RUN.
  - RUN:
    - IN_READY=0.
    - Each cycle the adder computes slice idx from opA_reg[32*idx+:32], opB_reg slice and carry reg (CIN).
    - At the edge: SUM[32*idx+:32] ← adder SUM, carry reg ← adder COUT, idx ← idx+1.
    - When idx==WORDS−1: instead, COUT ← adder COUT, OVF ← (A_msb ~^ Bop_msb) & (SUM_msb ^ A_msb), with Bop the inverted B for SUB. Go to DONE.
  - DONE:
    - OUT_VALID=1, IN_READY=0.
    - SUM, COUT and OVF are held stable until OUT_READY=1 at an edge; then → IDLE and OUT_VALID → 0.
- Latency: request accepted at edge k → OUT_VALID high after edge k+WORDS.
  - Earliest next accept is edge k+WORDS+2 (DONE handshake at k+WORDS+1, IDLE for one cycle).
- IN_VALID while IN_READY=0 is ignored. The producer must hold its request until it is accepted.
- A, B and SUB are only sampled at the accept edge. Changes afterward have no effect.
- SUM bits of slices not yet computed during RUN are don't-care to the consumer. Their reset value is 0, and they keep previous values until overwritten.
- WORDS=1: RUN lasts exactly one cycle. It is the final-slice case directly.
- The carry reg is never carried across operations; every operation reseeds it from SUB.
- OUT_READY asserted outside DONE has no effect.

Test Plan:
1. Carry ripple across slices (WORDS=4): A=0xFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, B=1, SUB=0 → SUM=0, COUT=1, OVF=0. OUT_VALID rises exactly 4 cycles after accept; IN_READY=0 throughout RUN/DONE.
2. Subtract with borrow: A=5, B=7, SUB=1 → SUM=0xFFFF…FFFE (128-bit), COUT=0, OVF=0. Also A=7, B=5, SUB=1 → SUM=2, COUT=1.
3. Signed overflow: A=0x7FFF…FFFF, B=1, SUB=0 → SUM=0x8000…0000, OVF=1, COUT=0. Also A=0x8000…0000, B=1, SUB=1 → SUM=0x7FFF…FFFF, OVF=1, COUT=1.
4. Backpressure: hold OUT_READY=0 for 10 cycles in DONE while toggling IN_VALID and changing A/B. SUM, COUT, OVF and OUT_VALID must stay constant and no new accept may occur. After an OUT_READY handshake, the next request is accepted one cycle later and produces its own correct result.
5. Reset mid-operation: RST_N=0 for one edge while idx==2 → next cycle OUT_VALID=0, SUM=0, COUT=0, IN_READY=1. A following request A=3, B=4 → SUM=7.
6. WORDS=1 build: A=0xFFFF_FFFF, B=0xFFFF_FFFF, SUB=0 → SUM=0xFFFF_FFFE, COUT=1, OVF=0, OUT_VALID 1 cycle after accept.
